xinput_reader: RTL and testbench

Memory-mapped input peripheral that brings the board push-button and the eight slide switches into the processor data bus. It is the read-side counterpart of the display/LED output peripherals. It synchronises both inputs, debounces the button through a state machine, and latches sticky press and switch-change events. The address decoder selects it with a single select line, and its read word joins the decoder's read-data mux.

---
 rtl/xinput_reader_pkg.sv | 23 ++
 rtl/xinput_reader_xdebounce.sv | 80 ++++++++
 rtl/xinput_reader.sv | 86 ++++++++
 tb/tb_xinput_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/xinput_reader_pkg.sv
// Shared definitions for the input peripheral: register map, STATUS layout
// and the debounce FSM state type.
package xinput_reader_pkg;

  localparam int unsigned DATA_W_DEFAULT    = 32;
  localparam logic [31:0] INPUT_BASE        = 32'h0000_1040;

  localparam int unsigned INPUT_STATUS_ADDR = 0;
  localparam int unsigned INPUT_SW_ADDR     = 1;

  localparam int unsigned STAT_PEND_BIT     = 0;
  localparam int unsigned STAT_LEVEL_BIT    = 1;
  localparam int unsigned STAT_SWCHG_BIT    = 2;
  localparam int unsigned STAT_CNT_LSB      = 8;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_PRESSED,
    DB_WAIT_RELEASE
  } db_state_e;

endpackage

// File: rtl/xinput_reader_xdebounce.sv
// Push-button synchroniser plus 4-state debounce FSM; emits a single-cycle
// press pulse when a high level has been stable long enough.
module xdebounce
  import xinput_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_q, state_d;
  logic             btn;

  assign btn = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= DB_IDLE;
    end else begin
      sync_q  <= {sync_q[0], raw};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A level reversal during either WAIT state abandons the stable-period count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (btn) begin
          state_d = DB_WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      DB_WAIT_PRESS: begin
        if (!btn) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESSED;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_PRESSED: begin
        if (!btn) begin
          state_d = DB_WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_WAIT_RELEASE: begin
        if (btn) begin
          state_d = DB_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign level = (state_q == DB_PRESSED) || (state_q == DB_WAIT_RELEASE);

endmodule

// File: rtl/xinput_reader.sv
// Memory-mapped push-button / slide-switch reader: sticky press and
// switch-change events, press counter, STATUS and SWITCH read registers.
module xinput_reader
  import xinput_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DATA_W          = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Btn3,
  input  logic [7:0]        Sw,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              btn_irq
);

  logic       level, press;
  logic [7:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic       pending_q, pending_d;
  logic       swchg_q, swchg_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_stat, clr_pend, clr_cnt, clr_swchg;
  logic       unused_data_bits;

  xdebounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (Btn3),
    .level(level),
    .press(press)
  );

  assign wr_stat   = sel && we && (addr == 1'(INPUT_STATUS_ADDR));
  assign clr_pend  = wr_stat && data_in[STAT_PEND_BIT];
  assign clr_cnt   = wr_stat && data_in[STAT_LEVEL_BIT];
  assign clr_swchg = wr_stat && data_in[STAT_SWCHG_BIT];
  assign unused_data_bits = ^data_in[DATA_W-1:3];

  // New events win over a clear landing in the same cycle.
  always_comb begin
    pending_d = (pending_q && !clr_pend) || press;
    cnt_d     = (clr_cnt ? 8'd0 : cnt_q) + {7'd0, press};
    swchg_d   = (swchg_q && !clr_swchg) || (sw_s2_q != sw_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
      pending_q <= 1'b0;
      swchg_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sw_s1_q   <= Sw;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
      pending_q <= pending_d;
      swchg_q   <= swchg_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      if (addr == 1'(INPUT_STATUS_ADDR)) begin
        data_out[STAT_PEND_BIT]       = pending_q;
        data_out[STAT_LEVEL_BIT]      = level;
        data_out[STAT_SWCHG_BIT]      = swchg_q;
        data_out[STAT_CNT_LSB +: 8]   = cnt_q;
      end else begin
        data_out[7:0] = sw_s2_q;
      end
    end
  end

  assign btn_irq = pending_q;

endmodule

// File: tb/tb_xinput_reader.sv
// Self-checking bench for xinput_reader with DEBOUNCE_CYCLES = 4.
module tb_xinput_reader;

  localparam int D  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, Btn3, sel, we, addr;
  logic [7:0]    Sw;
  logic [DW-1:0] data_in, data_out;
  logic          btn_irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xinput_reader #(
    .DEBOUNCE_CYCLES(D),
    .DATA_W         (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Btn3    (Btn3),
    .Sw      (Sw),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .btn_irq (btn_irq)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a level flips once the synced input has disagreed
  // with it for D+1 consecutive samples; the 0->1 flip is a press.
  bit       chk_en = 0;
  int       m_run;
  bit       m_lvl, m_pend, m_swc, m_b1, m_b2;
  logic [7:0] m_cnt, m_s1, m_s2, m_s3;

  always @(posedge clk) begin : model
    bit press, wr;
    if (rst) begin
      m_run = 0; m_lvl = 0; m_pend = 0; m_swc = 0; m_b1 = 0; m_b2 = 0;
      m_cnt = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
      chk_en = 1;
    end else begin
      press = 0;
      if (m_b2 != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_b2;
          m_run = 0;
          press = m_lvl;
        end
      end else begin
        m_run = 0;
      end
      wr = sel && we && (addr == 1'b0);
      m_pend = (m_pend && !(wr && data_in[0])) || press;
      if (wr && data_in[1]) m_cnt = 8'd0;
      if (press) m_cnt = m_cnt + 8'd1;
      m_swc = (m_swc && !(wr && data_in[2])) || (m_s2 != m_s3);
      m_b2 = m_b1; m_b1 = Btn3;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = Sw;
    end
  end

  always @(negedge clk) begin : compare
    logic [DW-1:0] exp;
    if (chk_en) begin
      exp = '0;
      if (sel) begin
        if (addr) exp = {24'd0, m_s2};
        else      exp = {16'd0, m_cnt, 5'd0, m_swc, m_lvl, m_pend};
      end
      check("model_data_out", data_out, exp);
      check("model_btn_irq", {31'd0, btn_irq}, {31'd0, m_pend});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a);
    sel = 1; we = 0; addr = a; data_in = '0;
    #1;
  endtask

  task automatic wr(input logic a, input logic [DW-1:0] d);
    sel = 1; we = 1; addr = a; data_in = d;
    tick(1);
    sel = 0; we = 0; data_in = '0;
  endtask

  task automatic press_once();
    Btn3 = 1; tick(8);
    Btn3 = 0; tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; Btn3 = 0; Sw = '0; sel = 0; we = 0; addr = 0; data_in = '0;
    tick(3);
    rst = 0;
    rd(0);
    check("reset_status", data_out, 32'h0);
    check("reset_irq", {31'd0, btn_irq}, 32'h0);

    // clean press: pending appears 6 edges after Btn3 is first sampled
    Btn3 = 1;
    tick(6); check("press_not_early", {31'd0, btn_irq}, 32'h0);
    tick(1); check("press_latency", {31'd0, btn_irq}, 32'h1);
    tick(13); rd(0);
    check("clean_status", data_out, 32'h0103);
    Btn3 = 0;
    tick(6); rd(0); check("release_not_early", data_out, 32'h0103);
    tick(1); rd(0); check("release_level", data_out, 32'h0101);
    wr(0, 32'h1); rd(0);
    check("pend_clear", data_out, 32'h0100);

    // bounce: 2-cycle glitches never qualify
    for (int i = 0; i < 8; i++) begin
      Btn3 = (i % 2 == 0);
      tick(2);
    end
    Btn3 = 1;
    tick(6); check("bounce_no_early", {31'd0, btn_irq}, 32'h0);
    tick(1); check("bounce_press", {31'd0, btn_irq}, 32'h1);
    rd(0); check("bounce_count", data_out, 32'h0203);
    Btn3 = 0; tick(8);

    // clear collision with press
    wr(0, 32'h1);
    Btn3 = 1; tick(6);
    sel = 1; we = 1; addr = 0; data_in = 32'h3;
    tick(1);
    sel = 0; we = 0; data_in = '0;
    rd(0); check("collide_status", data_out, 32'h0103);
    wr(0, 32'h1); rd(0);
    check("late_clear", data_out, 32'h0102);
    check("late_clear_irq", {31'd0, btn_irq}, 32'h0);
    Btn3 = 0; tick(8);

    // counter wrap
    wr(0, 32'h2);
    for (int i = 0; i < 256; i++) press_once();
    rd(0); check("wrap_zero", data_out, 32'h0001);
    press_once();
    rd(0); check("wrap_one", data_out, 32'h0101);
    wr(0, 32'h2); rd(0);
    check("count_clear", data_out, 32'h0001);

    // switches
    Sw = 8'hA5;
    tick(1); rd(1); check("sw_not_early", data_out, 32'h0);
    tick(1); rd(1); check("sw_readback", data_out, 32'h00A5);
    tick(1); rd(0); check("sw_changed", data_out, 32'h0005);
    wr(0, 32'h4); rd(0);
    check("sw_clear", data_out, 32'h0001);
    sel = 0; #1;
    check("desel_zero", data_out, 32'h0);
    Sw = 8'h5A;
    tick(2);
    sel = 1; we = 1; addr = 0; data_in = 32'h4;
    tick(1);
    sel = 0; we = 0; data_in = '0;
    rd(0); check("sw_collide", data_out, 32'h0005);
    wr(0, 32'h5);

    // reset while in WAIT_PRESS with counter at 2
    Btn3 = 1; tick(5);
    rst = 1; tick(1); rst = 0;
    rd(0); check("midreset_status", data_out, 32'h0);
    tick(6); check("midreset_no_press", {31'd0, btn_irq}, 32'h0);
    tick(1); check("midreset_restart", {31'd0, btn_irq}, 32'h1);
    Btn3 = 0; tick(10);
    sel = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
